// File: rtl/tl_d_channel_slave_if.sv
// TileLink D-channel beat bundle between the response generator and the master.
// The slave drives the beat and its last flag; the master answers with ready.
interface tl_d_channel_slave_if;
  logic        s_d_valid;
  logic        m_d_ready;
  logic [73:0] o_d_header;
  logic        o_d_last;

  modport slave (
    output s_d_valid,
    output o_d_header,
    output o_d_last,
    input  m_d_ready
  );

  modport master (
    input  s_d_valid,
    input  o_d_header,
    input  o_d_last,
    output m_d_ready
  );
endinterface

// File: rtl/tl_d_channel_slave.sv
// Pops A-channel requests and answers AccessAck (Put) or AccessAckData bursts (Get); one request in flight.
// Put: beat one cycle after pop. Get: 3 cycles per beat. A stalled beat holds until m_d_ready; no read while stalled.
module tl_d_channel_slave #(
  parameter int band_width = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [36:0]          i_request,
  input  logic                 i_empty_FIFO_request,
  output logic                 o_pop_request,
  output logic                 o_ren,
  output logic [32:0]          o_raddr,
  input  logic [63:0]          i_rdata,
  tl_d_channel_slave_if.slave  d,
  output logic                 o_drop
);

  typedef struct packed {
    logic [2:0]  code;
    logic [2:0]  size;
    logic [3:0]  mark;
    logic [26:0] address;
  } req_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [3:0]  mark;
    logic [63:0] data;
  } hdr_t;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    READ,
    WAIT,
    SEND
  } state_t;

  localparam logic [2:0] CODE_PUT      = 3'b000;
  localparam logic [2:0] CODE_GET      = 3'b001;
  localparam logic [2:0] OP_ACCESS_ACK = 3'd0;
  localparam logic [2:0] OP_ACK_DATA   = 3'd1;

  // Index of the final beat; a 16-beat burst wraps to 15 in 4 bits.
  function automatic logic [3:0] last_beat(input logic [2:0] sz);
    logic [8:0] n;
    n = 9'd1;
    if (int'(sz) >= band_width) begin
      n = 9'd1 << (int'(sz) - band_width);
    end
    return n[3:0] - 4'd1;
  endfunction

  req_t        req;
  hdr_t        hdr;
  state_t      state_q;
  state_t      state_d;
  logic [2:0]  size_q;
  logic [3:0]  mark_q;
  logic [26:0] addr_q;
  logic [3:0]  beat_q;
  logic [3:0]  last_q;
  logic [63:0] data_q;
  logic        load;
  logic        capture;
  logic        beat_inc;
  logic        is_last;

  assign req     = i_request;
  assign is_last = (beat_q == last_q);

  assign d.o_d_header = hdr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q <= '0;
      mark_q <= '0;
      addr_q <= '0;
      last_q <= '0;
      beat_q <= '0;
      data_q <= '0;
    end else begin
      if (load) begin
        size_q <= req.size;
        mark_q <= req.mark;
        addr_q <= req.address;
        last_q <= last_beat(req.size);
        beat_q <= '0;
      end else if (beat_inc) begin
        beat_q <= beat_q + 4'd1;
      end
      if (capture) begin
        data_q <= i_rdata;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    o_pop_request = 1'b0;
    o_drop        = 1'b0;
    o_ren         = 1'b0;
    o_raddr       = '0;
    d.s_d_valid   = 1'b0;
    d.o_d_last    = 1'b0;
    hdr           = '0;
    load          = 1'b0;
    capture       = 1'b0;
    beat_inc      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!i_empty_FIFO_request) begin
          o_pop_request = 1'b1;
          load          = 1'b1;
          case (req.code)
            CODE_PUT: state_d = ACK;
            CODE_GET: state_d = READ;
            default:  o_drop  = 1'b1;
          endcase
        end
      end

      ACK: begin
        d.s_d_valid = 1'b1;
        d.o_d_last  = 1'b1;
        hdr         = '{opcode: OP_ACCESS_ACK, size: size_q, mark: mark_q, data: 64'd0};
        if (d.m_d_ready) begin
          state_d = IDLE;
        end
      end

      READ: begin
        o_ren   = 1'b1;
        o_raddr = {addr_q, 6'b0} + (33'(beat_q) << band_width);
        state_d = WAIT;
      end

      WAIT: begin
        capture = 1'b1;
        state_d = SEND;
      end

      SEND: begin
        d.s_d_valid = 1'b1;
        d.o_d_last  = is_last;
        hdr         = '{opcode: OP_ACK_DATA, size: size_q, mark: mark_q, data: data_q};
        if (d.m_d_ready) begin
          // Counter also advances on the final beat, so 15 wraps back to 0.
          beat_inc = 1'b1;
          state_d  = is_last ? IDLE : READ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tl_d_channel_slave.sv
// Directed table-driven bench for tl_d_channel_slave with a FIFO and 1-cycle memory model.
module tb_tl_d_channel_slave;
  localparam int BW = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [36:0] i_request = '0;
  logic        i_empty_FIFO_request = 1'b1;
  logic        o_pop_request;
  logic        o_ren;
  logic [32:0] o_raddr;
  logic [63:0] i_rdata = '0;
  logic        o_drop;

  tl_d_channel_slave_if dif ();

  tl_d_channel_slave #(.band_width(BW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_request            (i_request),
    .i_empty_FIFO_request (i_empty_FIFO_request),
    .o_pop_request        (o_pop_request),
    .o_ren                (o_ren),
    .o_raddr              (o_raddr),
    .i_rdata              (i_rdata),
    .d                    (dif.slave),
    .o_drop               (o_drop)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [2:0]  code;
    logic [2:0]  size;
    logic [3:0]  mark;
    logic [26:0] addr;
    int          stall;
    int          exp_beats;
    logic [2:0]  exp_op;
    int          exp_drop;
  } vec_t;

  localparam logic [63:0] DATA_TAG = 64'hA5A5_0000_0000_0000;

  int          checks = 0;
  int          errors = 0;
  logic [36:0] q[$];
  logic [32:0] mem_base = '0;
  vec_t        vecs[8];
  vec_t        b2b[3];

  logic        s_pop, s_drop, s_ren, s_valid, s_last;
  logic [32:0] s_raddr;
  logic [73:0] s_hdr;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_fifo();
    i_empty_FIFO_request = (q.size() == 0);
    i_request = (q.size() == 0) ? 37'd0 : q[0];
  endtask

  task automatic sample();
    @(negedge clk);
    s_pop   = o_pop_request;
    s_drop  = o_drop;
    s_ren   = o_ren;
    s_raddr = o_raddr;
    s_valid = dif.s_d_valid;
    s_hdr   = dif.o_d_header;
    s_last  = dif.o_d_last;
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({o_pop_request, o_drop, o_ren, o_raddr, dif.s_d_valid, dif.o_d_header, dif.o_d_last});
  endfunction

  task automatic advance();
    logic [32:0] off;
    @(posedge clk);
    #1;
    if (s_pop && q.size() > 0) q.delete(0);
    if (s_ren) begin
      off = s_raddr - mem_base;
      i_rdata = DATA_TAG | 64'(off >> BW);
    end
    drive_fifo();
  endtask

  task automatic run_vec(input string tag, input vec_t v, input bit do_push);
    int cyc, pop_cyc, acc_cyc, k, rens, pops, drops, stall_left;
    bit done, fv, rdy;
    logic [32:0] base;
    logic [73:0] exp_hdr;
    base = {v.addr, 6'b0};
    mem_base = base;
    if (do_push) begin
      q.push_back({v.code, v.size, v.mark, v.addr});
      drive_fifo();
    end
    cyc = 0; pop_cyc = -100; acc_cyc = -100; k = 0; rens = 0; pops = 0; drops = 0;
    stall_left = v.stall; done = 0; fv = 0;
    while (!done && cyc < 300) begin
      sample();
      rdy = 1'b1;
      if (s_pop) begin
        pops++;
        pop_cyc = cyc;
        chk({tag, "_pop_cycle"}, 128'(cyc), 128'(0));
      end
      if (s_drop) drops++;
      if (s_ren) begin
        chk($sformatf("%s_raddr%0d", tag, rens), 128'(s_raddr), 128'(33'(base + (33'(rens) << BW))));
        chk($sformatf("%s_ren_cycle%0d", tag, rens), 128'(cyc),
            128'((rens == 0) ? pop_cyc + 1 : acc_cyc + 1));
        rens++;
      end
      if (s_valid) begin
        if (!fv) begin
          fv = 1;
          chk({tag, "_first_valid_cycle"}, 128'(cyc), 128'(pop_cyc + ((v.exp_op == 3'd1) ? 3 : 1)));
        end
        exp_hdr = {v.exp_op, v.size, v.mark, (v.exp_op == 3'd1) ? (DATA_TAG | 64'(k)) : 64'd0};
        chk($sformatf("%s_hdr%0d", tag, k), 128'(s_hdr), 128'(exp_hdr));
        chk($sformatf("%s_last%0d", tag, k), 128'(s_last), 128'(k == v.exp_beats - 1));
        if (k == 0 && stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end
        if (rdy) begin
          acc_cyc = cyc;
          k++;
          if (s_last || k >= v.exp_beats) done = 1;
        end
      end
      if (s_drop && v.exp_drop != 0) done = 1;
      dif.m_d_ready = rdy;
      advance();
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no completion expected completion within 300 cycles", tag);
    end
    chk({tag, "_pops"}, 128'(pops), 128'(1));
    chk({tag, "_beats"}, 128'(k), 128'(v.exp_beats));
    chk({tag, "_drops"}, 128'(drops), 128'(v.exp_drop));
    chk({tag, "_rens"}, 128'(rens), 128'((v.exp_op == 3'd1 && v.exp_drop == 0) ? v.exp_beats : 0));
  endtask

  initial begin
    //       code  size  mark   addr          stall beats op    drop
    vecs[0] = '{3'd0, 3'd3, 4'hA, 27'h0000123, 0, 1,  3'd0, 0};
    vecs[1] = '{3'd1, 3'd5, 4'h5, 27'h0000010, 0, 4,  3'd1, 0};
    vecs[2] = '{3'd1, 3'd4, 4'h3, 27'h0000020, 5, 2,  3'd1, 0};
    vecs[3] = '{3'd1, 3'd7, 4'hF, 27'h7FFFFFF, 0, 16, 3'd1, 0};
    vecs[4] = '{3'd1, 3'd1, 4'h6, 27'h0000033, 0, 1,  3'd1, 0};
    vecs[5] = '{3'd0, 3'd0, 4'h0, 27'h0000005, 3, 1,  3'd0, 0};
    vecs[6] = '{3'd4, 3'd2, 4'h9, 27'h0000001, 0, 0,  3'd0, 1};
    vecs[7] = '{3'd1, 3'd3, 4'hC, 27'h0000100, 2, 1,  3'd1, 0};
    b2b[0]  = '{3'd0, 3'd2, 4'h1, 27'h0000010, 0, 1,  3'd0, 0};
    b2b[1]  = '{3'd7, 3'd3, 4'h2, 27'h0000020, 0, 0,  3'd0, 1};
    b2b[2]  = '{3'd1, 3'd3, 4'h2, 27'h0000040, 0, 1,  3'd1, 0};

    dif.m_d_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs(), 128'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk($sformatf("idle_empty%0d", i), 128'({s_pop, s_drop, s_ren, s_raddr, s_valid, s_hdr, s_last}), 128'(0));
      advance();
    end

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i], 1'b1);

    // Three requests queued together to exercise back-to-back pops and the drop path.
    for (int i = 0; i < 3; i++) q.push_back({b2b[i].code, b2b[i].size, b2b[i].mark, b2b[i].addr});
    drive_fifo();
    for (int i = 0; i < 3; i++) run_vec($sformatf("b2b%0d", i), b2b[i], 1'b0);
    chk("b2b_fifo_drained", 128'(q.size()), 128'(0));

    // Reset asserted while the second beat of a 4-beat Get is on the bus.
    begin
      int nb;
      bit hit;
      nb = 0;
      hit = 0;
      mem_base = 33'h400;
      q.push_back({3'd1, 3'd5, 4'h5, 27'h0000010});
      drive_fifo();
      dif.m_d_ready = 1'b1;
      for (int c = 0; c < 40 && !hit; c++) begin
        sample();
        if (s_valid) begin
          if (nb == 1) hit = 1;
          else nb++;
        end
        if (!hit) advance();
      end
      chk("rst_mid_send_reached", 128'(hit), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_outputs", all_outs(), 128'(0));
      @(posedge clk);
      #3 rst_n = 1'b1;
      drive_fifo();
      for (int i = 0; i < 6; i++) begin
        sample();
        chk($sformatf("post_rst_idle%0d", i), 128'({s_pop, s_drop, s_ren, s_raddr, s_valid, s_hdr, s_last}), 128'(0));
        advance();
      end
      run_vec("post_rst_put", vecs[0], 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
